// File: rtl/muldiv_unit_if.sv
// Start/result handshake and HI/LO access between the EX stage
// and the multi-cycle multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    output wr_hi, wr_lo, wdata,
    input  busy, done, div_by_zero,
    input  hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  wr_hi, wr_lo, wdata,
    output busy, done, div_by_zero,
    output hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with HI/LO.
// One iteration per cycle on operand magnitudes, sign fix-up at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               zero_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // acc_q: multiply = {partial product, multiplier};
  // divide = {remainder, dividend/quotient bits}
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_d;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_d;
  logic [2*WIDTH-1:0] acc_d;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + ({1'b0, dvs_q} & {(WIDTH+1){acc_q[0]}});
    mul_d   = {mul_sum, acc_q[WIDTH-1:1]};

    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = div_sh >= {1'b0, dvs_q};
    div_diff = div_sh[WIDTH-1:0] - dvs_q;
    if (div_ge) begin
      div_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    acc_d = is_div_q ? div_d : mul_d;
  end

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // Divide by zero leaves the dividend magnitude as remainder, so the
  // remainder sign fix restores the original dividend.
  always_comb begin
    hi_d = acc_q[2*WIDTH-1:WIDTH];
    lo_d = acc_q[WIDTH-1:0];
    if (is_div_q) begin
      if (neg_res_q) lo_d = -acc_q[WIDTH-1:0];
      if (neg_rem_q) hi_d = -acc_q[2*WIDTH-1:WIDTH];
      if (zero_q)    lo_d = '1;
    end else if (neg_res_q) begin
      {hi_d, lo_d} = -acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      dvs_q     <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            cnt_q     <= CW'(WIDTH-1);
            is_div_q  <= bus.op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            zero_q    <= bus.op[1] & (bus.b == '0);
            dvs_q     <= b_mag;
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
          end else begin
            if (bus.wr_hi) hi_q <= bus.wdata;
            if (bus.wr_lo) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          dbz_q   <= zero_q;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors queue expected
// HI/LO/flag/latency, a negedge monitor pops on every done pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 expected none at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, bus.hi, e.hi);
        chk({e.name, "_lo"}, bus.lo, e.lo);
        chk({e.name, "_dbz"}, W'(bus.div_by_zero), W'(e.dbz));
        chk({e.name, "_lat"}, W'(cyc), W'(e.cyc));
        chk({e.name, "_busy"}, W'(bus.busy), '0);
      end
    end
  end

  // Called right after a negedge; start is sampled at the next posedge.
  task automatic issue(string name, logic [1:0] op, logic [W-1:0] a,
                       logic [W-1:0] b, logic [W-1:0] ehi,
                       logic [W-1:0] elo, logic edbz);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e.hi   = ehi;
    e.lo   = elo;
    e.dbz  = edbz;
    e.cyc  = cyc + 1 + W + 1;
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.a     = 32'hA5A5_5A5A;
    bus.b     = 32'h0F0F_F0F0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checks++;
    $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.wr_hi = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wdata = '0;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_dbz", W'(bus.div_by_zero), '0);
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);

    issue("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    bus.wr_hi = 1'b1;
    bus.wdata = 32'hDEAD_0000;
    bus.start = 1'b1;
    bus.op    = 2'b10;
    bus.a     = 32'd5;
    bus.b     = 32'd0;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    bus.start = 1'b0;
    chk("mthi_busy", bus.hi, '0);
    chk("busy_run", W'(bus.busy), W'(1));
    wait_done("multu_max");

    @(negedge clk);
    bus.wr_hi = 1'b1;
    bus.wdata = 32'hDEAD_0000;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    chk("mthi_idle_hi", bus.hi, 32'hDEAD_0000);
    chk("mthi_idle_lo", bus.lo, 32'h0000_0001);

    bus.wr_lo = 1'b1;
    bus.wr_hi = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 32'hFFFF_FFFD;
    bus.b     = 32'h0000_0007;
    begin
      exp_t e;
      e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFEB; e.dbz = 1'b0;
      e.cyc = cyc + 1 + W + 1; e.name = "mult_neg";
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    bus.wr_hi = 1'b0;
    chk("mt_start_prio", bus.lo, 32'h0000_0001);
    wait_done("mult_neg");

    @(negedge clk);
    issue("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done("div_neg");
    @(negedge clk);
    issue("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_done("divu_100_7");
    @(negedge clk);
    issue("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE,
          32'd1, 32'hFFFF_FFFD, 1'b0);
    wait_done("div_7_m2");
    @(negedge clk);
    issue("div_m7_z", 2'b11, 32'hFFFF_FFF9, 32'd0,
          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_m7_z");
    @(negedge clk);
    issue("divu_z", 2'b10, 32'h1234_5678, 32'd0,
          32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    wait_done("divu_z");

    repeat (3) @(negedge clk);
    chk("dbz_sticky", W'(bus.div_by_zero), W'(1));
    issue("mulu_small", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
    chk("dbz_clear", W'(bus.div_by_zero), '0);

    // Back-to-back: new start driven during the done cycle.
    wait_done("mulu_small");
    issue("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0);
    chk("b2b_busy", W'(bus.busy), W'(1));
    wait_done("div_min_m1");

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", W'(bus.busy), '0);
    chk("abort_done", W'(bus.done), '0);
    chk("abort_hi", bus.hi, '0);
    chk("abort_lo", bus.lo, '0);
    repeat (50) @(negedge clk);

    chk("sb_empty", W'(sb.size()), '0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
